// File: rtl/sysarr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysarr_pkg
// Brief    : Shared widths and row type for the 2x2 systolic array slice.
// Revision : 1.0 - initial release
// ============================================================================
package sysarr_pkg;

    localparam int MACC_W = 16;
    localparam int COLS   = 2;
    localparam int ROW_W  = MACC_W * COLS;

    // Column 1 sits in element [0], column 2 in element [1].
    typedef logic [COLS-1:0][MACC_W-1:0] row_t;

endpackage
`default_nettype wire

// File: rtl/row_fifo.sv
`default_nettype none
// ============================================================================
// Module   : row_fifo
// Brief    : Registered-output row FIFO, DEPTH entries, no fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module row_fifo
    import sysarr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  row_t push_data,
    input  logic pop,
    output row_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    row_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic            w_pop;
    logic            w_push;

    assign w_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= push_data;
    end

    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    // Empty reads as zero so stale storage never shows on the output.
    assign pop_data = empty ? '0 : r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/sum_deskew.sv
`default_nettype none
// ============================================================================
// Module   : sum_deskew
// Brief    : Re-aligns the skewed column outputs of a 2x2 systolic array into
//            32-bit rows and buffers them. Optional row counter enabled by
//            defining SUM_DESKEW_ROWCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sum_deskew
    import sysarr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              activeout1,
    input  logic              activeout2,
    input  logic [MACC_W-1:0] maccout1,
    input  logic [MACC_W-1:0] maccout2,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [ROW_W-1:0]  row_data,
    output logic              full,
    output logic              overflow,
    output logic              skew_err,
    output logic [7:0]        row_count
);

    logic              r_d1_valid;
    logic [MACC_W-1:0] r_d1_data;
    logic              r_overflow;
    logic              r_skew_err;

    logic              w_row_form;
    logic              w_pop;
    logic              w_drop;
    logic              w_empty;
    row_t              w_row;
    row_t              w_head;

    // Column 2 lags column 1 by one cycle; the delayed column 1 pairs with it.
    assign w_row_form = activeout2 & r_d1_valid;
    assign w_row[1]   = maccout2;
    assign w_row[0]   = r_d1_data;

    assign row_valid  = ~w_empty;
    assign w_pop      = row_valid & row_ready;
    assign w_drop     = w_row_form & full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1_valid <= 1'b0;
            r_d1_data  <= '0;
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            r_d1_valid <= activeout1;
            r_d1_data  <= maccout1;
            if (w_drop)                   r_overflow <= 1'b1;
            if (activeout2 ^ r_d1_valid)  r_skew_err <= 1'b1;
        end
    end

    row_fifo #(
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_row_form),
        .push_data (w_row),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (full),
        .empty     (w_empty)
    );

    assign row_data = w_head;
    assign overflow = r_overflow;
    assign skew_err = r_skew_err;

`ifdef SUM_DESKEW_ROWCNT_EN
    logic       w_accept;
    logic [7:0] r_row_count;

    // Counts rows that actually entered storage; drops are excluded.
    assign w_accept = w_row_form & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (reset)         r_row_count <= '0;
        else if (w_accept) r_row_count <= r_row_count + 8'd1;
    end

    assign row_count = r_row_count;
`else
    assign row_count = '0;
`endif

endmodule
`default_nettype wire
